uart_block_packer: RTL and testbench
====================================

# uart_block_packer

Collects the byte stream produced by the UART receiver and packs every 16 consecutive bytes into one 128-bit plaintext block for the AES core. It sits between the UART RX deserializer and the AES input in the UART/AES string loopback path. It decouples the two sides with one collect register plus one output register and a valid/ready handshake. It also discards stale partial blocks after an inter-byte timeout and flags bytes dropped on overrun.

## Interface
- BLOCK_BYTES, 16: bytes per block; block width is BLOCK_BYTES*8.
- TIMEOUT_CYCLES, 1_000_000: idle clocks after which a partial block is discarded (10 ms at 100 MHz, about 115 byte times at 115200 baud); must be ≥ 2.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; sampled only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe from the UART RX.
- blk_data  out  128  packed block, stable while blk_valid is high.
- blk_valid  out  1  block available to AES.
- blk_ready  in  1  AES accepts the block on a cycle where blk_valid && blk_ready.
- byte_count  out  5  bytes currently held in the collect register (0..16).
- overrun  out  1  one-cycle pulse: an incoming byte was dropped.
- timeout  out  1  one-cycle pulse: a partial block was discarded.

## Operation
- Byte order: the first byte of a block lands in blk_data[127:120] and the 16th in [7:0]. Example: bytes 0x11..0x20 give 0x1112...1f20.
- Collect-side states:
  - IDLE (count=0): rx_valid stores the byte at index 0, count=1, goes to COLLECT.
  - COLLECT (1..15 bytes): rx_valid stores the byte at index count and increments count. Reaching 16 goes to FULL.
  - FULL (16 bytes): waits until the output register is free, then transfers and returns to IDLE.
- Output register: loaded from the collect register when the collect side is FULL and the output is free. Free means blk_valid is low, or blk_valid && blk_ready in the same cycle.
- Transfer occurs on the cycle FULL is first seen free. Back-to-back blocks therefore flow without a bubble when AES is ready.
- rx_valid in FULL: the byte is dropped, overrun pulses, and state is unchanged.
  - Exception: if the transfer happens in that same cycle, the byte is stored as index 0 of the next block and no overrun is raised.
- Timeout: an idle counter runs only in COLLECT. It clears on every accepted byte.
  - It expires when it reaches TIMEOUT_CYCLES-1 in a cycle with rx_valid low. On expiry, count clears, state goes to IDLE and timeout pulses.
  - If rx_valid is high in the expiry cycle, the byte is accepted, the counter restarts and no timeout occurs.
- No timeout in IDLE or FULL. A full block is never discarded.
- Stale bytes beyond count in the collect register are don't-care. They are overwritten before use.

## Timing
- Reset: all outputs and state registers clear at the first clk edge with rst high. This gives blk_valid=0, blk_data=0, byte_count=0, overrun=0, timeout=0, state IDLE and idle counter 0.
- Reset mid-block or with blk_valid high discards everything. No handshake completes in the reset cycle.
- byte_count updates the cycle after the accepting edge.
- Latency: 16th byte strobed on edge N puts the collect side in FULL after N. With the output free, blk_valid is high after edge N+1, so it is visible one cycle after FULL.
- blk_valid, once high, stays high with blk_data unchanged until the accepting handshake edge.
- overrun and timeout are registered and high for exactly one cycle, in the cycle after the causing edge.
- Idle counter width is $clog2(TIMEOUT_CYCLES). There is no wrap, because it saturates via expiry.

## Structure
- Shared package aes_uart_pkg holds:
  - AES_BLOCK_BITS=128 and BLOCK_BYTES=16;
  - typedefs byte_t (logic [7:0]) and block_t (logic [127:0]);
  - the collect-state enum {IDLE, COLLECT, FULL}.
- One sub-module, uart_idle_timer: a clear/enable counter with an expiry output, parameterized by TIMEOUT_CYCLES. The block instantiates it with TIMEOUT_CYCLES overridden to 200 in simulation.

## Test plan
- Send bytes 0x11..0x20 with blk_ready=1 -> one handshake with blk_data=0x1112131415161718191a1b1c1d1e1f20; overrun=0, timeout=0.
- Send 5 bytes, idle past TIMEOUT_CYCLES, then 16 bytes 0x00..0x0f -> timeout pulses once. The block equals 0x000102030405060708090a0b0c0d0e0f, with no leftover from the partial block.
- Hold blk_ready=0 and send 33 bytes -> first block held in the output register and the second reaches FULL. Byte 33 raises overrun; blk_data is unchanged until ready rises. The second block then appears exactly one cycle after the first handshake.
- Hold blk_ready=0 and send 32 bytes, then strobe byte 33 in the same cycle blk_ready rises -> no overrun. Byte 33 becomes index 0 of the third block and byte_count reads 1.
- Strobe rx_valid exactly in the timeout expiry cycle -> no timeout pulse, and byte_count increments.
- Assert rst after 8 bytes, with blk_valid high from a prior block -> all outputs 0 next cycle. The next 16 bytes form a clean block.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// ============================================================================
// Module  : aes_uart_pkg
// Brief   : Shared types and constants for the UART/AES string loopback path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_uart_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int BLOCK_BYTES    = 16;

  typedef logic [7:0]                byte_t;
  typedef logic [AES_BLOCK_BITS-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } collect_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_idle_timer.sv
// ============================================================================
// Module  : uart_idle_timer
// Brief   : Clear/enable idle counter; o_expired flags the final count value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  // Holding at the last value keeps the counter from wrapping if the owner
  // leaves it enabled past expiry.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_en && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_block_packer.sv
// ============================================================================
// Module  : uart_block_packer
// Brief   : Packs 16 UART RX bytes into one 128-bit AES block (valid/ready).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_block_packer
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [4:0]   byte_count,
  output logic         overrun,
  output logic         timeout
);

  localparam int c_IDX_W = $clog2(BLOCK_BYTES);
  localparam int c_CNT_W = $clog2(BLOCK_BYTES + 1);

  collect_state_t r_state;
  byte_t          r_collect [BLOCK_BYTES];
  block_t         w_collect_blk;

  logic w_out_free;
  logic w_xfer;
  logic w_last_byte;
  logic w_timer_expired;
  logic w_expire;
  logic w_timer_en;
  logic w_timer_clr;

  // First received byte occupies the most significant lane.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_pack
    assign w_collect_blk[(BLOCK_BYTES-1-gi)*8 +: 8] = r_collect[gi];
  end

  assign w_out_free  = !blk_valid || blk_ready;
  assign w_xfer      = (r_state == FULL) && w_out_free;
  assign w_last_byte = (byte_count == c_CNT_W'(BLOCK_BYTES - 1));

  assign w_timer_en  = (r_state == COLLECT);
  assign w_timer_clr = (r_state != COLLECT) || rx_valid;
  assign w_expire    = w_timer_expired && !rx_valid;

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expired(w_timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      byte_count <= '0;
      blk_data   <= '0;
      blk_valid  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        r_collect[i] <= '0;
      end
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;

      if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_collect[0] <= rx_data;
            byte_count   <= c_CNT_W'(1);
            r_state      <= COLLECT;
          end
        end

        COLLECT: begin
          if (rx_valid) begin
            r_collect[byte_count[c_IDX_W-1:0]] <= rx_data;
            byte_count <= byte_count + 1'b1;
            if (w_last_byte) begin
              r_state <= FULL;
            end
          end else if (w_expire) begin
            byte_count <= '0;
            timeout    <= 1'b1;
            r_state    <= IDLE;
          end
        end

        FULL: begin
          if (w_xfer) begin
            blk_data  <= w_collect_blk;
            blk_valid <= 1'b1;
            // A byte arriving in the transfer cycle starts the next block.
            if (rx_valid) begin
              r_collect[0] <= rx_data;
              byte_count   <= c_CNT_W'(1);
              r_state      <= COLLECT;
            end else begin
              byte_count <= '0;
              r_state    <= IDLE;
            end
          end else if (rx_valid) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          byte_count <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_block_packer.sv
// ============================================================================
// Module  : tb_uart_block_packer
// Brief   : Directed self-checking bench for uart_block_packer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_block_packer;

  localparam int c_TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [4:0]   byte_count;
  logic         overrun;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  logic [127:0] hs_q [$];
  int           ov_cnt = 0;
  int           to_cnt = 0;

  uart_block_packer #(
    .TIMEOUT_CYCLES(c_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .byte_count(byte_count),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so negedge values match the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_valid && blk_ready) hs_q.push_back(blk_data);
      if (overrun) ov_cnt++;
      if (timeout) to_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 40 && hs_q.size() < target; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; blk_ready = 1'b0;
    repeat (2) tick();
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", blk_valid); end
    total++; if (blk_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", blk_data); end
    total++; if (byte_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", byte_count); end
    total++; if ({overrun, timeout} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {overrun, timeout}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int base = hs_q.size(); int ov0 = ov_cnt; int to0 = to_cnt;
    logic [127:0] exp = 128'h1112131415161718191a1b1c1d1e1f20;
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h11 + i));
    total++; if (byte_count !== 5'd16) begin bad++; $display("FAIL basic_full_count got=%0d exp=16", byte_count); end
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL basic_latency_early got=%b exp=0", blk_valid); end
    tick();
    total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", blk_valid); end
    total++; if (byte_count !== 5'd0) begin bad++; $display("FAIL basic_count_after got=%0d exp=0", byte_count); end
    wait_hs(base + 1);
    total++; if (hs_q.size() !== base + 1) begin bad++; $display("FAIL basic_hs_count got=%0d exp=%0d", hs_q.size(), base + 1); end
    else begin
      total++; if (hs_q[base] !== exp) begin bad++; $display("FAIL basic_data got=%h exp=%h", hs_q[base], exp); end
    end
    repeat (2) tick();
    total++; if (ov_cnt !== ov0 || to_cnt !== to0) begin bad++; $display("FAIL basic_pulses got=%0d/%0d exp=%0d/%0d", ov_cnt, to_cnt, ov0, to0); end
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", blk_valid); end
  endtask

  task automatic test_timeout();
    int base = hs_q.size(); int to0 = to_cnt;
    logic [127:0] exp = 128'h000102030405060708090a0b0c0d0e0f;
    blk_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'ha0 + i));
    total++; if (byte_count !== 5'd5) begin bad++; $display("FAIL to_partial got=%0d exp=5", byte_count); end
    repeat (c_TIMEOUT - 1) tick();
    total++; if (timeout !== 1'b0 || to_cnt !== to0 || byte_count !== 5'd5) begin
      bad++; $display("FAIL to_early got=%b cnt=%0d exp=0 cnt=5", timeout, byte_count); end
    tick();
    total++; if (timeout !== 1'b1 || byte_count !== 5'd0) begin
      bad++; $display("FAIL to_expire got=%b cnt=%0d exp=1 cnt=0", timeout, byte_count); end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_width got=%b exp=0", timeout); end
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    wait_hs(base + 1);
    total++; if (hs_q.size() !== base + 1) begin bad++; $display("FAIL to_hs_count got=%0d exp=%0d", hs_q.size(), base + 1); end
    else begin
      total++; if (hs_q[base] !== exp) begin bad++; $display("FAIL to_clean_block got=%h exp=%h", hs_q[base], exp); end
    end
    total++; if (to_cnt !== to0 + 1) begin bad++; $display("FAIL to_once got=%0d exp=%0d", to_cnt, to0 + 1); end
  endtask

  task automatic test_timeout_edge();
    int base = hs_q.size(); int to0 = to_cnt;
    logic [127:0] exp = 128'h55565758595a5b5c5d5e5f6061626364;
    blk_ready = 1'b1;
    send_byte(8'h55);
    repeat (c_TIMEOUT - 1) tick();
    send_byte(8'h56);
    total++; if (timeout !== 1'b0 || byte_count !== 5'd2) begin
      bad++; $display("FAIL toedge_accept got=%b cnt=%0d exp=0 cnt=2", timeout, byte_count); end
    repeat (3) tick();
    total++; if (to_cnt !== to0) begin bad++; $display("FAIL toedge_no_pulse got=%0d exp=%0d", to_cnt, to0); end
    for (int i = 0; i < 14; i++) send_byte(8'(8'h57 + i));
    wait_hs(base + 1);
    total++; if (hs_q.size() !== base + 1) begin bad++; $display("FAIL toedge_hs got=%0d exp=%0d", hs_q.size(), base + 1); end
    else begin
      total++; if (hs_q[base] !== exp) begin bad++; $display("FAIL toedge_data got=%h exp=%h", hs_q[base], exp); end
    end
  endtask

  task automatic test_overrun();
    int base = hs_q.size(); int ov0 = ov_cnt;
    logic [127:0] b1 = 128'h404142434445464748494a4b4c4d4e4f;
    logic [127:0] b2 = 128'h505152535455565758595a5b5c5d5e5f;
    blk_ready = 1'b0;
    for (int i = 0; i < 33; i++) send_byte(8'(8'h40 + i));
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    total++; if (byte_count !== 5'd16 || blk_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_hold got cnt=%0d v=%b exp cnt=16 v=1", byte_count, blk_valid); end
    tick();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_width got=%b exp=0", overrun); end
    repeat (5) tick();
    total++; if (blk_data !== b1) begin bad++; $display("FAIL ovr_stable got=%h exp=%h", blk_data, b1); end
    total++; if (ov_cnt !== ov0 + 1) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", ov_cnt, ov0 + 1); end
    blk_ready = 1'b1;
    tick();
    total++; if (blk_valid !== 1'b1 || blk_data !== b2) begin
      bad++; $display("FAIL ovr_next got v=%b d=%h exp v=1 d=%h", blk_valid, blk_data, b2); end
    total++; if (byte_count !== 5'd0) begin bad++; $display("FAIL ovr_count_after got=%0d exp=0", byte_count); end
    wait_hs(base + 2);
    total++; if (hs_q.size() !== base + 2) begin bad++; $display("FAIL ovr_hs got=%0d exp=%0d", hs_q.size(), base + 2); end
    else begin
      total++; if (hs_q[base] !== b1 || hs_q[base+1] !== b2) begin
        bad++; $display("FAIL ovr_order got=%h,%h exp=%h,%h", hs_q[base], hs_q[base+1], b1, b2); end
    end
  endtask

  task automatic test_same_cycle();
    int base = hs_q.size(); int ov0 = ov_cnt;
    logic [127:0] ba = 128'h606162636465666768696a6b6c6d6e6f;
    logic [127:0] bb = 128'h707172737475767778797a7b7c7d7e7f;
    logic [127:0] bc = 128'h808182838485868788898a8b8c8d8e8f;
    blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'(8'h60 + i));
    rx_data = 8'h80; rx_valid = 1'b1; blk_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL same_no_overrun got=%b exp=0", overrun); end
    total++; if (byte_count !== 5'd1) begin bad++; $display("FAIL same_count got=%0d exp=1", byte_count); end
    total++; if (blk_valid !== 1'b1 || blk_data !== bb) begin
      bad++; $display("FAIL same_second got v=%b d=%h exp v=1 d=%h", blk_valid, blk_data, bb); end
    for (int i = 1; i < 16; i++) send_byte(8'(8'h80 + i));
    wait_hs(base + 3);
    total++; if (hs_q.size() !== base + 3) begin bad++; $display("FAIL same_hs got=%0d exp=%0d", hs_q.size(), base + 3); end
    else begin
      total++; if (hs_q[base] !== ba || hs_q[base+1] !== bb || hs_q[base+2] !== bc) begin
        bad++; $display("FAIL same_blocks got=%h,%h,%h", hs_q[base], hs_q[base+1], hs_q[base+2]); end
    end
    total++; if (ov_cnt !== ov0) begin bad++; $display("FAIL same_ov_count got=%0d exp=%0d", ov_cnt, ov0); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [127:0] exp = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    blk_ready = 1'b0;
    for (int i = 0; i < 24; i++) send_byte(8'(8'h90 + i));
    total++; if (blk_valid !== 1'b1 || byte_count !== 5'd8) begin
      bad++; $display("FAIL rstmid_pre got v=%b cnt=%0d exp v=1 cnt=8", blk_valid, byte_count); end
    rst = 1'b1; blk_ready = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (blk_valid !== 1'b0 || blk_data !== 128'h0 || byte_count !== 5'd0 || overrun !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear got v=%b d=%h cnt=%0d o=%b t=%b exp all 0", blk_valid, blk_data, byte_count, overrun, timeout); end
    base = hs_q.size();
    for (int i = 0; i < 16; i++) send_byte(8'(8'hc0 + i));
    wait_hs(base + 1);
    total++; if (hs_q.size() !== base + 1) begin bad++; $display("FAIL rstmid_hs got=%0d exp=%0d", hs_q.size(), base + 1); end
    else begin
      total++; if (hs_q[base] !== exp) begin bad++; $display("FAIL rstmid_block got=%h exp=%h", hs_q[base], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_edge();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
